phase_sweep_ctrl: RTL and testbench

- Frequency-sweep (chirp) controller that sits directly upstream of the phase accumulator.
- It generates the accumulator's tuning word D, its clr pulse and its add_sub direction.
- It steps D linearly from a start word to a stop word, holding each word for a programmable dwell time.
- It supports single or continuous sweeps, in sawtooth or triangle profile, so the accumulator/DDS chain produces linear FM without CPU involvement.

---
 rtl/phase_sweep_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_phase_sweep_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sweep_ctrl.sv
// Chirp controller feeding the phase accumulator: walks the tuning word from
// f_start to f_stop (sawtooth or triangle), holding each word dwell+1 cycles.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for start; D forced to 0 so the accumulator is frozen
//   ST_RUN  | sweep in progress; config latched, inputs other than stop ignored
module phase_sweep_ctrl #(
  parameter int WIDTH   = 16,
  parameter int DWELL_W = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
  input  logic               continuous_i,
  input  logic               dir_i,
  input  logic [WIDTH-1:0]   f_start_i,
  input  logic [WIDTH-1:0]   f_stop_i,
  input  logic [WIDTH-1:0]   f_step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [WIDTH-1:0]   d_o,
  output logic               clr_o,
  output logic               add_sub_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               wrap_o
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  typedef enum logic {LEG_UP, LEG_DOWN} leg_t;

  state_t             state_q, state_d;
  leg_t               leg_q, leg_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               clr_q, clr_d;
  logic               add_sub_q, add_sub_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   f_start_q, f_start_d;
  logic [WIDTH-1:0]   f_stop_q, f_stop_d;
  logic [WIDTH-1:0]   f_step_q, f_step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               cont_q, cont_d;

  logic [WIDTH:0]     room_up, room_dn, step_ext;
  logic [WIDTH-1:0]   up_word, dn_word;
  logic               degenerate;

  // One extra bit keeps the room-to-boundary math from wrapping near 2^WIDTH-1.
  always_comb begin
    step_ext   = {1'b0, f_step_q};
    room_up    = {1'b0, f_stop_q} - {1'b0, d_q};
    room_dn    = {1'b0, d_q} - {1'b0, f_start_q};
    up_word    = (room_up > step_ext) ? d_q + f_step_q : f_stop_q;
    dn_word    = (room_dn > step_ext) ? d_q - f_step_q : f_start_q;
    degenerate = (f_step_q == '0) || (f_start_q >= f_stop_q);
  end

  always_comb begin
    state_d   = state_q;
    leg_d     = leg_q;
    d_d       = d_q;
    clr_d     = 1'b0;
    add_sub_d = add_sub_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    cnt_d     = cnt_q;
    f_start_d = f_start_q;
    f_stop_d  = f_stop_q;
    f_step_d  = f_step_q;
    dwell_d   = dwell_q;
    mode_d    = mode_q;
    cont_d    = cont_q;
    case (state_q)
      ST_IDLE: begin
        d_d = '0;
        if (start_i && !stop_i) begin
          state_d   = ST_RUN;
          f_start_d = f_start_i;
          f_stop_d  = f_stop_i;
          f_step_d  = f_step_i;
          dwell_d   = dwell_i;
          mode_d    = mode_i;
          cont_d    = continuous_i;
          add_sub_d = dir_i;
          d_d       = f_start_i;
          clr_d     = 1'b1;
          cnt_d     = dwell_i;
          leg_d     = LEG_UP;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          d_d     = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          cnt_d = dwell_q;
          if (degenerate) begin
            if (cont_q) begin
              d_d    = f_start_q;
              wrap_d = 1'b1;
              leg_d  = LEG_UP;
            end else begin
              state_d = ST_IDLE;
              d_d     = '0;
              done_d  = 1'b1;
            end
          end else if (leg_q == LEG_UP) begin
            if (d_q != f_stop_q) begin
              d_d = up_word;
            end else if (!mode_q) begin
              if (cont_q) begin
                d_d    = f_start_q;
                wrap_d = 1'b1;
              end else begin
                state_d = ST_IDLE;
                d_d     = '0;
                done_d  = 1'b1;
              end
            end else begin
              leg_d = LEG_DOWN;
              d_d   = dn_word;
            end
          end else begin
            if (d_q != f_start_q) begin
              d_d = dn_word;
            end else if (cont_q) begin
              leg_d  = LEG_UP;
              d_d    = up_word;
              wrap_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
              d_d     = '0;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        d_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      leg_q     <= LEG_UP;
      d_q       <= '0;
      clr_q     <= 1'b0;
      add_sub_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      cnt_q     <= '0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      dwell_q   <= '0;
      mode_q    <= 1'b0;
      cont_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      leg_q     <= leg_d;
      d_q       <= d_d;
      clr_q     <= clr_d;
      add_sub_q <= add_sub_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      cnt_q     <= cnt_d;
      f_start_q <= f_start_d;
      f_stop_q  <= f_stop_d;
      f_step_q  <= f_step_d;
      dwell_q   <= dwell_d;
      mode_q    <= mode_d;
      cont_q    <= cont_d;
    end
  end

  assign d_o       = d_q;
  assign clr_o     = clr_q;
  assign add_sub_o = add_sub_q;
  assign busy_o    = (state_q == ST_RUN);
  assign done_o    = done_q;
  assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Directed bench for phase_sweep_ctrl; outputs sampled 1ns after each rising edge.
module tb_phase_sweep_ctrl;

  logic        clock = 1'b0;
  logic        reset, start, stop, mode, continuous, dir;
  logic [15:0] f_start, f_stop, f_step, dwell;
  logic [15:0] d;
  logic        clr, add_sub, busy, done, wrap;

  int n_pass  = 0;
  int n_total = 0;

  phase_sweep_ctrl #(.WIDTH(16), .DWELL_W(16)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .stop_i(stop),
    .mode_i(mode), .continuous_i(continuous), .dir_i(dir),
    .f_start_i(f_start), .f_stop_i(f_stop), .f_step_i(f_step), .dwell_i(dwell),
    .d_o(d), .clr_o(clr), .add_sub_o(add_sub), .busy_o(busy),
    .done_o(done), .wrap_o(wrap)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic configure(input logic m, input logic c, input logic dr,
                           input int fs, input int fp, input int st, input int dw);
    mode = m; continuous = c; dir = dr;
    f_start = 16'(fs); f_stop = 16'(fp); f_step = 16'(st); dwell = 16'(dw);
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    configure(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    n_total++;
    if ({d, clr, add_sub, busy, done, wrap} !== 21'd0)
      $display("FAIL reset_outputs got=%h want=0", {d, clr, add_sub, busy, done, wrap});
    else n_pass++;
    reset = 1'b0;
    tick();
    n_total++;
    if ({d, busy} !== 17'd0) $display("FAIL idle_after_reset got d=%0d busy=%0b want 0/0", d, busy);
    else n_pass++;
  endtask

  task automatic test_saw_single();
    int exp_d [8];
    exp_d = '{100, 100, 200, 200, 300, 300, 400, 400};
    configure(0, 0, 1, 100, 400, 100, 1);
    launch();
    n_total++;
    if (add_sub !== 1'b1) $display("FAIL saw_add_sub got=%0b want=1", add_sub);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (d !== 16'(exp_d[i]) || clr !== (i == 0) || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL saw_single[%0d] got d=%0d clr=%0b busy=%0b done=%0b want d=%0d clr=%0b busy=1 done=0",
                 i, d, clr, busy, done, exp_d[i], (i == 0));
      else n_pass++;
      tick();
    end
    n_total++;
    if (d !== 16'd0 || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL saw_single_end got d=%0d done=%0b busy=%0b want 0/1/0", d, done, busy);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0) $display("FAIL saw_single_done_width got=%0b want=0", done);
    else n_pass++;
  endtask

  task automatic test_saw_clamp();
    int exp_d [4];
    exp_d = '{100, 200, 300, 350};
    configure(0, 0, 0, 100, 350, 100, 0);
    launch();
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (d !== 16'(exp_d[i]) || done !== 1'b0)
        $display("FAIL saw_clamp[%0d] got d=%0d done=%0b want d=%0d done=0", i, d, done, exp_d[i]);
      else n_pass++;
      tick();
    end
    n_total++;
    if (d !== 16'd0 || done !== 1'b1) $display("FAIL saw_clamp_end got d=%0d done=%0b want 0/1", d, done);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL saw_clamp_idle got done=%0b busy=%0b want 0/0", done, busy);
    else n_pass++;
  endtask

  task automatic test_tri_cont();
    int   exp_d [10];
    logic exp_w [10];
    exp_d = '{100, 200, 300, 200, 100, 200, 300, 200, 100, 200};
    exp_w = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    configure(1, 1, 0, 100, 300, 100, 0);
    launch();
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (d !== 16'(exp_d[i]) || wrap !== exp_w[i] || done !== 1'b0)
        $display("FAIL tri_cont[%0d] got d=%0d wrap=%0b done=%0b want d=%0d wrap=%0b done=0",
                 i, d, wrap, done, exp_d[i], exp_w[i]);
      else n_pass++;
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_total++;
    if (d !== 16'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL tri_stop got d=%0d busy=%0b done=%0b want 0/0/0", d, busy, done);
    else n_pass++;
  endtask

  task automatic test_stop_relaunch();
    configure(0, 1, 0, 100, 300, 100, 2);
    launch();
    for (int i = 0; i < 11; i++) begin
      n_total++;
      if (d !== 16'(100 + 100 * ((i / 3) % 3)) || wrap !== (i == 9))
        $display("FAIL saw_cont[%0d] got d=%0d wrap=%0b want d=%0d wrap=%0b",
                 i, d, wrap, 100 + 100 * ((i / 3) % 3), (i == 9));
      else n_pass++;
      if (i < 10) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_total++;
    if ({d, busy, done, wrap, clr} !== 20'd0)
      $display("FAIL stop_mid_hold got d=%0d busy=%0b done=%0b wrap=%0b clr=%0b want all 0",
               d, busy, done, wrap, clr);
    else n_pass++;
    tick();
    launch();
    n_total++;
    if (d !== 16'd100 || clr !== 1'b1 || busy !== 1'b1)
      $display("FAIL relaunch got d=%0d clr=%0b busy=%0b want 100/1/1", d, clr, busy);
    else n_pass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_overflow();
    configure(0, 0, 0, 65000, 65535, 1000, 0);
    launch();
    n_total++;
    if (d !== 16'd65000) $display("FAIL ovf_first got=%0d want=65000", d);
    else n_pass++;
    tick();
    n_total++;
    if (d !== 16'd65535) $display("FAIL ovf_clamp got=%0d want=65535", d);
    else n_pass++;
    tick();
    n_total++;
    if (d !== 16'd0 || done !== 1'b1) $display("FAIL ovf_end got d=%0d done=%0b want 0/1", d, done);
    else n_pass++;
    tick();
  endtask

  task automatic test_degenerate();
    configure(0, 1, 0, 500, 600, 0, 1);
    launch();
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (d !== 16'd500 || wrap !== (i == 2 || i == 4))
        $display("FAIL degen[%0d] got d=%0d wrap=%0b want d=500 wrap=%0b", i, d, wrap, (i == 2 || i == 4));
      else n_pass++;
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_ignore_and_reset();
    int exp_d [3];
    exp_d = '{200, 300, 200};
    configure(1, 0, 1, 100, 300, 100, 0);
    launch();
    start = 1'b1;
    configure(0, 1, 0, 5, 9000, 7, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (d !== 16'(exp_d[i]) || clr !== 1'b0 || busy !== 1'b1)
        $display("FAIL start_in_run[%0d] got d=%0d clr=%0b busy=%0b want d=%0d clr=0 busy=1",
                 i, d, clr, busy, exp_d[i]);
      else n_pass++;
    end
    reset = 1'b1;
    start = 1'b0;
    tick();
    n_total++;
    if ({d, clr, add_sub, busy, done, wrap} !== 21'd0)
      $display("FAIL reset_mid_sweep got=%h want=0", {d, clr, add_sub, busy, done, wrap});
    else n_pass++;
    reset = 1'b0;
    tick();
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL post_reset got done=%0b busy=%0b want 0/0", done, busy);
    else n_pass++;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    tick();
    n_total++;
    if (busy !== 1'b0 || clr !== 1'b0 || d !== 16'd0)
      $display("FAIL start_stop_idle got busy=%0b clr=%0b d=%0d want 0/0/0", busy, clr, d);
    else n_pass++;
    start = 1'b0;
    stop  = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_saw_single();
    test_saw_clamp();
    test_tri_cont();
    test_stop_relaunch();
    test_overflow();
    test_degenerate();
    test_ignore_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
